// File: rtl/store_wbuf_pkg.sv
// Shared types and lane-formatting helpers for the store write buffer.
// Optional feature macro used by this slice: STORE_WBUF_FWD_EN.
package store_wbuf_pkg;

    // Entries always carry a 64-bit address field; narrower AW is zero-extended.
    localparam int unsigned ENTRY_AW = 64;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } st_size_e;

    typedef struct packed {
        logic [ENTRY_AW-1:0] waddr;
        logic [63:0]         wdata;
        logic [7:0]          wmask;
    } wbuf_entry_t;

    function automatic logic [7:0] size_to_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (off[0] == 1'b0);
            SZ_W:    ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Generic DEPTH-deep FIFO with wrap-bit pointers and a combinational head read.
// With STORE_WBUF_FWD_EN it also exposes every slot and its occupancy.
module wbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
`ifdef STORE_WBUF_FWD_EN
    ,
    output logic [DEPTH-1:0]             slot_valid,
    output logic [DEPTH-1:0][WIDTH-1:0]  slot_data
`endif
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    always_comb begin
        full     = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
        empty    = (wr_ptr_q == rd_ptr_q);
        count    = wr_ptr_q - rd_ptr_q;
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
        if (pop_ok)  rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage is deliberately left unreset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q[PW-1:0]];

`ifdef STORE_WBUF_FWD_EN
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PW-1:0] dist;
            // A slot is live when its distance from the head is below the occupancy.
            assign dist           = PW'(gi) - rd_ptr_q[PW-1:0];
            assign slot_valid[gi] = ({1'b0, dist} < count);
            assign slot_data[gi]  = mem_q[gi];
        end
    endgenerate
`endif

endmodule

// File: rtl/store_wbuf.sv
// Store write buffer: formats CPU stores into aligned 64-bit beats and queues them to memory.
// STORE_WBUF_FWD_EN adds ld_addr/ld_conflict for load-vs-buffered-store hazard detection.
module store_wbuf
    import store_wbuf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [AW-1:0]          st_addr,
    input  logic [63:0]            st_data,
    input  logic [1:0]             st_size,
    output logic                   st_misalign,
    output logic                   mem_wvalid,
    input  logic                   mem_wready,
    output logic [AW-1:0]          mem_waddr,
    output logic [63:0]            mem_wdata,
    output logic [7:0]             mem_wmask,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
`ifdef STORE_WBUF_FWD_EN
    ,
    input  logic [AW-1:0]          ld_addr,
    output logic                   ld_conflict
`endif
);
    localparam int EW = $bits(wbuf_entry_t);

    logic [2:0]  off;
    logic [7:0]  base_mask;
    logic [63:0] lane_keep;
    logic        aligned, accept, push, pop, full;
    logic        misalign_q, misalign_d;
    wbuf_entry_t new_entry, head_entry;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_keep
            assign lane_keep[gi*8 +: 8] = {8{base_mask[gi]}};
        end
    endgenerate

    always_comb begin
        off               = st_addr[2:0];
        base_mask         = size_to_mask(st_size, 3'd0);
        aligned           = is_aligned(st_size, off);
        accept            = st_valid && st_ready;
        push              = accept && aligned;
        // A misaligned store is consumed and dropped; only the flag records it.
        misalign_d        = accept && !aligned;
        new_entry.waddr   = ENTRY_AW'({st_addr[AW-1:3], 3'b000});
        new_entry.wdata   = (st_data & lane_keep) << {off, 3'b000};
        new_entry.wmask   = size_to_mask(st_size, off);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end

`ifdef STORE_WBUF_FWD_EN
    logic [DEPTH-1:0]          slot_valid;
    logic [DEPTH-1:0][EW-1:0]  slot_data;
    logic [DEPTH-1:0]          slot_hit;
    logic [ENTRY_AW-1:0]       ld_line;
`endif

    wbuf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .wdata      (new_entry),
        .pop        (pop),
        .rdata      (head_entry),
        .full       (full),
        .empty      (empty),
        .count      (count)
`ifdef STORE_WBUF_FWD_EN
        ,
        .slot_valid (slot_valid),
        .slot_data  (slot_data)
`endif
    );

    assign st_ready    = !full;
    assign st_misalign = misalign_q;
    assign mem_wvalid  = !empty;
    assign pop         = mem_wvalid && mem_wready;
    assign mem_waddr   = head_entry.waddr[AW-1:0];
    assign mem_wdata   = head_entry.wdata;
    assign mem_wmask   = head_entry.wmask;

`ifdef STORE_WBUF_FWD_EN
    assign ld_line = ENTRY_AW'({ld_addr[AW-1:3], 3'b000});
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
            // waddr is the most significant field of the packed entry.
            assign slot_hit[gi] = slot_valid[gi] && (slot_data[gi][EW-1 -: ENTRY_AW] == ld_line);
        end
    endgenerate
    assign ld_conflict = |slot_hit;
`endif

endmodule

// File: tb/tb_store_wbuf.sv
// Directed self-checking bench for store_wbuf (DEPTH=4, AW=64).
// Forwarding checks are included when STORE_WBUF_FWD_EN is defined.
module tb_store_wbuf;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic [1:0]  st_size;
    logic        st_misalign;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [2:0]  count;
    logic        empty;
`ifdef STORE_WBUF_FWD_EN
    logic [63:0] ld_addr;
    logic        ld_conflict;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  m;
    } exp_t;
    exp_t q[$];
    exp_t e;

    store_wbuf #(.DEPTH(4), .AW(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_size     (st_size),
        .st_misalign (st_misalign),
        .mem_wvalid  (mem_wvalid),
        .mem_wready  (mem_wready),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .count       (count),
        .empty       (empty)
`ifdef STORE_WBUF_FWD_EN
        ,
        .ld_addr     (ld_addr),
        .ld_conflict (ld_conflict)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        st_valid   = 1'b0;
        st_addr    = '0;
        st_data    = '0;
        st_size    = 2'd0;
        mem_wready = 1'b0;
`ifdef STORE_WBUF_FWD_EN
        ld_addr    = '0;
`endif
        step();
        step();
        $display("reset state");
        chk("rst_st_ready", st_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_wvalid", mem_wvalid, 0);
        chk("rst_misalign", st_misalign, 0);
        reset = 1'b1;
        step();

        // Byte store at offset 5
        $display("byte store 0x80000005");
        st_valid = 1'b1; st_addr = 64'h8000_0005; st_data = 64'hAB; st_size = 2'd0;
        mem_wready = 1'b1;
        chk("b_ready", st_ready, 1);
        chk("b_no_bypass", mem_wvalid, 0);
        step();
        st_valid = 1'b0;
        chk("b_wvalid", mem_wvalid, 1);
        chk("b_waddr", mem_waddr, 64'h8000_0000);
        chk("b_wmask", mem_wmask, 8'h20);
        chk("b_wdata", mem_wdata, 64'h0000_AB00_0000_0000);
        chk("b_count", count, 1);
        step();
        chk("b_empty", empty, 1);
        chk("b_wvalid0", mem_wvalid, 0);

        // Misaligned half store
        $display("misaligned half 0x80000003");
        st_valid = 1'b1; st_addr = 64'h8000_0003; st_data = 64'h1234; st_size = 2'd1;
        chk("m_ready", st_ready, 1);
        chk("m_flag_pre", st_misalign, 0);
        step();
        st_valid = 1'b0;
        chk("m_flag", st_misalign, 1);
        chk("m_count", count, 0);
        chk("m_wvalid", mem_wvalid, 0);
        step();
        chk("m_flag_clr", st_misalign, 0);
        chk("m_wvalid2", mem_wvalid, 0);

        // Fill to full with backpressure, fifth store held off
        mem_wready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            $display("dword push %0d", i);
            st_valid = 1'b1;
            st_addr  = 64'h1000 + 64'(i) * 8;
            st_data  = 64'hD0D0_0000_0000_0000 | 64'(i);
            st_size  = 2'd3;
            chk("f_ready", st_ready, (i < 4) ? 1 : 0);
            chk("f_count", count, 64'(i < 4 ? i : 4));
            step();
        end
        chk("f_full_count", count, 4);
        chk("f_full_ready", st_ready, 0);
        chk("f_head_addr", mem_waddr, 64'h1000);
        chk("f_head_data", mem_wdata, 64'hD0D0_0000_0000_0000);
        chk("f_head_mask", mem_wmask, 8'hFF);
        // Full with push and pop both requested: only the pop happens
        mem_wready = 1'b1;
        step();
        $display("full push+pop");
        chk("fp_count", count, 3);
        chk("fp_ready", st_ready, 1);
        chk("fp_head1", mem_waddr, 64'h1008);
        step();
        st_valid = 1'b0;
        chk("fp_count_same", count, 3);
        chk("fp_head2", mem_waddr, 64'h1010);
        step();
        chk("fp_head3", mem_waddr, 64'h1018);
        chk("fp_data3", mem_wdata, 64'hD0D0_0000_0000_0003);
        step();
        chk("fp_head4", mem_waddr, 64'h1020);
        chk("fp_data4", mem_wdata, 64'hD0D0_0000_0000_0004);
        chk("fp_count4", count, 1);
        step();
        chk("fp_empty", empty, 1);

        // Pointer wrap with word stores, upper data bits must be masked off
        for (int i = 0; i < 10; i++) begin
            $display("wrap pair %0d", i);
            st_valid = 1'b1;
            st_addr  = 64'h2000 + 64'(i) * 8 + ((i % 2 == 1) ? 64'd4 : 64'd0);
            st_data  = 64'hFFFF_FFFF_0000_0000 | 64'(i);
            st_size  = 2'd2;
            chk("w_count", count, 64'(q.size()));
            chk("w_wvalid", mem_wvalid, (q.size() != 0) ? 1 : 0);
            if (q.size() != 0) begin
                chk("w_addr", mem_waddr, q[0].a);
                chk("w_data", mem_wdata, q[0].d);
                chk("w_mask", mem_wmask, q[0].m);
            end
            step();
            if (q.size() != 0) void'(q.pop_front());
            e.a = 64'h2000 + 64'(i) * 8;
            e.d = (i % 2 == 1) ? (64'(i) << 32) : 64'(i);
            e.m = (i % 2 == 1) ? 8'hF0 : 8'h0F;
            q.push_back(e);
        end
        st_valid = 1'b0;
        chk("w_last_addr", mem_waddr, q[0].a);
        chk("w_last_data", mem_wdata, q[0].d);
        step();
        void'(q.pop_front());
        chk("w_empty", empty, 1);

        // Buffer three stores, probe forwarding, then reset mid-handshake
        mem_wready = 1'b0;
        st_size = 2'd3;
        st_valid = 1'b1; st_addr = 64'h8000_0000; st_data = 64'h11;
        step();
        st_addr = 64'h3008; st_data = 64'h22;
        step();
        st_addr = 64'h3010; st_data = 64'h33;
        step();
        st_valid = 1'b0;
        $display("three buffered");
        chk("r_count3", count, 3);
`ifdef STORE_WBUF_FWD_EN
        ld_addr = 64'h8000_0004;
        #1 chk("fw_hit_head", ld_conflict, 1);
        ld_addr = 64'h3014;
        #1 chk("fw_hit_tail", ld_conflict, 1);
        ld_addr = 64'h4000;
        #1 chk("fw_miss", ld_conflict, 0);
        ld_addr = 64'h8000_0004;
`endif
        mem_wready = 1'b1;
`ifdef STORE_WBUF_FWD_EN
        #1 chk("fw_hit_popping", ld_conflict, 1);
`endif
        step();
        mem_wready = 1'b0;
        chk("r_count2", count, 2);
`ifdef STORE_WBUF_FWD_EN
        chk("fw_after_drain", ld_conflict, 0);
`endif
        st_valid = 1'b1; st_addr = 64'h3018; st_data = 64'h44;
        step();
        st_valid = 1'b0;
        chk("r_count3b", count, 3);
        mem_wready = 1'b1;
        chk("r_wvalid_pre", mem_wvalid, 1);
        $display("async reset mid-handshake");
        reset = 1'b0;
        #1;
        chk("r_wvalid", mem_wvalid, 0);
        chk("r_empty", empty, 1);
        chk("r_count", count, 0);
        chk("r_ready", st_ready, 1);
`ifdef STORE_WBUF_FWD_EN
        ld_addr = 64'h3010;
        #1 chk("r_fw", ld_conflict, 0);
`endif
        step();
        reset = 1'b1;
        step();
        chk("r_post_empty", empty, 1);
        chk("r_post_wvalid", mem_wvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_wbuf.md
Name: store_wbuf

Overview:
- Write-side counterpart of the instruction-fetch read path: accepts CPU store requests and drains them to data memory as aligned 64-bit beats with a byte mask.
- Sits between the execute/LSU stage and the memory write port.
- FIFO-buffered, so the pipeline does not stall on memory write backpressure until the buffer is full.

Parameters:
- DEPTH, 4, number of store-buffer entries; power of 2, at least 2.
- AW, 64, address width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- st_valid  in  1  store request valid.
- st_ready  out  1  buffer can accept; equals !full.
- st_addr  in  AW  byte address of store.
- st_data  in  64  store data, right-aligned (LSBs).
- st_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- st_misalign  out  1  one-cycle pulse: previous-cycle request was misaligned and dropped.
- mem_wvalid  out  1  head entry presented to memory.
- mem_wready  in  1  memory accepts beat.
- mem_waddr  out  AW  8-byte-aligned address: {addr[AW-1:3], 3'b000}.
- mem_wdata  out  64  lane-shifted data.
- mem_wmask  out  8  byte-enable mask.
- count  out  log2(DEPTH)+1  occupied entries.
- empty  out  1  no buffered stores; used by fence/ebreak drain logic.

Behaviour:
- Storage: DEPTH entries of {waddr, wdata, wmask}. Read/write pointers are log2(DEPTH)+1 bits wide; the extra bit is a wrap bit.
  - full = same index, different wrap bit.
  - empty = pointers equal.
- Lane formatting on enqueue, with off = st_addr[2:0]:
  - wdata = st_data << (off*8). Bits above the size are masked to zero before shifting.
  - wmask = ((1 << (1 << st_size)) - 1) << off, truncated to 8 bits.
- Alignment rule: misaligned when off mod (1 << st_size) != 0.
- Push on (st_valid & st_ready & aligned). The entry is written at that edge and the write pointer advances.
- Misaligned request while st_ready:
  - Not enqueued; counts as consumed, with no retry.
  - st_misalign = 1 for exactly the next cycle.
- Pop on (mem_wvalid & mem_wready); the read pointer advances.
- mem_wvalid = !empty. mem_waddr, mem_wdata and mem_wmask are driven combinationally from the head entry. They stay stable while mem_wvalid & !mem_wready.
- Latency: a store accepted at edge N appears on mem_w* in the cycle after edge N. There is no combinational bypass from st_* to mem_w*.
- Simultaneous push and pop:
  - Not full: both occur; count unchanged.
  - Full: st_ready = 0 during that cycle, so only the pop occurs. No same-cycle refill.
- Order: strictly FIFO. Stores reach memory in acceptance order; no write merging.
- Wrap-around: index wraps modulo DEPTH and the wrap bit toggles.
- Reset (async assert, synchronous-release-safe):
  - Pointers = 0, count = 0, empty = 1, st_ready = 1, mem_wvalid = 0, st_misalign = 0.
  - Buffered stores are discarded, including one mid-handshake.
  - Entry storage need not be reset.
- Outputs while empty: mem_waddr, mem_wdata and mem_wmask are don't-care; the bench must not check them.

Optional Feature:
- STORE_WBUF_FWD_EN adds two ports: ld_addr (in, AW) and ld_conflict (out, 1).
- Defined: ld_conflict = 1 combinationally when any valid entry has waddr == {ld_addr[AW-1:3], 3'b000}. The LSU stalls the load while it is high. An entry popping this cycle still counts as valid this cycle.
- Undefined: the ports are absent, and the LSU must drain (wait for empty) before loads that may alias.

Decomposition:
- Shared package store_wbuf_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - entry struct typedef {waddr, wdata, wmask};
  - function size_to_mask(size, off);
  - function is_aligned(size, off).
- One natural sub-module, wbuf_fifo: a generic DEPTH-deep FIFO with wrap-bit pointers, full/empty/count. store_wbuf wraps it with formatting, misalign and forwarding logic.

Test Plan:
- Byte store, addr 0x8000_0005, data 0xAB, size 0, mem_wready=1 -> next cycle mem_waddr=0x8000_0000, mem_wmask=0x20, mem_wdata=0x0000_AB00_0000_0000; popped; empty=1 the following cycle.
- Half store at 0x8000_0003 -> st_ready stays 1, st_misalign=1 for one cycle, count stays 0, mem_wvalid stays 0.
- mem_wready=0, push 5 dword stores (DEPTH=4) -> st_ready=0 after 4 pushes, count=4, 5th held off; release mem_wready -> 4 beats drained in order, then 5th accepted.
- Full, with push and pop asserted in the same cycle -> only the pop occurs, count 4->3, st_ready=1 next cycle.
- Run 10 push/pop pairs through DEPTH=4 to exercise pointer wrap -> every beat matches a scoreboard in order; count never exceeds 4.
- Assert reset low with 3 entries buffered and mem_wvalid=1 -> immediately mem_wvalid=0, empty=1, count=0. With STORE_WBUF_FWD_EN, ld_addr=0x8000_0004 against buffered 0x8000_0000 -> ld_conflict=1; after drain -> 0.
